// File: rtl/stream_write_sequencer_if.sv
// Node-packet handshake and distribution-memory write bundle shared by the
// streaming address unit, the write sequencer and the destination memory.
interface stream_write_sequencer_if #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [9*ADDRESS_WIDTH-1:0] in_addresses;
    logic [9*DATA_WIDTH-1:0]    in_f;
    logic                       mem_busy;
    logic                       mem_we;
    logic [3:0]                 mem_dir;
    logic [ADDRESS_WIDTH-2:0]   mem_addr;
    logic [DATA_WIDTH-1:0]      mem_wdata;
    logic                       node_done;
    logic                       frame_done;
    logic [ADDRESS_WIDTH-2:0]   node_count;

    // Upstream packet source plus memory backpressure.
    modport master (
        output in_valid, in_addresses, in_f, mem_busy,
        input  in_ready, mem_we, mem_dir, mem_addr, mem_wdata,
               node_done, frame_done, node_count
    );

    // Write sequencer.
    modport slave (
        input  in_valid, in_addresses, in_f, mem_busy,
        output in_ready, mem_we, mem_dir, mem_addr, mem_wdata,
               node_done, frame_done, node_count
    );
endinterface

// File: rtl/stream_write_sequencer.sv
// Latches one node packet (9 streaming addresses + 9 distributions) and
// writes it to the destination memory one direction per cycle, skipping
// out-of-grid targets and stalling on memory backpressure.
module stream_write_sequencer #(
    parameter int GRID_DIM      = 16*16,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM)+1,
    parameter int DATA_WIDTH    = 16
) (
    input logic                     clk,
    input logic                     reset,
    stream_write_sequencer_if.slave bus
);
    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam logic [AW-2:0] LAST_NODE = (AW-1)'(GRID_DIM-1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      dir_q, dir_d;
    logic [9*AW-1:0] addr_q, addr_d;
    logic [9*DW-1:0] f_q, f_d;
    logic [AW-2:0]   count_q, count_d;
    logic            node_done_q, node_done_d;
    logic            frame_done_q, frame_done_d;

    logic [AW-1:0]   entry_addr;
    logic [DW-1:0]   entry_data;
    logic            entry_invalid;
    logic            advance;
    logic            last_dir;
    logic            ready;
    logic            take;

    // Select the latched slice for the current direction (dir0 is the MSB slice).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        entry_addr = '0;
        entry_data = '0;
        for (int i = 0; i < 9; i++) begin
            if (dir_q == 4'(i)) begin
                entry_addr = addr_q[(8-i)*AW +: AW];
                entry_data = f_q[(8-i)*DW +: DW];
            end
        end
    end

    // Next-state, handshake and counter logic.
    always_comb begin
        entry_invalid = entry_addr[AW-1];
        advance       = (state_q == WRITE) && (entry_invalid || !bus.mem_busy);
        last_dir      = advance && (dir_q == 4'd8);
        ready         = (state_q == IDLE) || last_dir;
        take          = bus.in_valid && ready;

        state_d      = state_q;
        dir_d        = dir_q;
        addr_d       = addr_q;
        f_d          = f_q;
        count_d      = count_q;
        node_done_d  = 1'b0;
        frame_done_d = 1'b0;

        if (take) begin
            addr_d  = bus.in_addresses;
            f_d     = bus.in_f;
            dir_d   = 4'd0;
            state_d = WRITE;
        end

        case (state_q)
            IDLE: ;
            WRITE: begin
                if (last_dir) begin
                    node_done_d = 1'b1;
                    if (count_q == LAST_NODE) begin
                        count_d      = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                    if (!take) begin
                        state_d = IDLE;
                    end
                end else if (advance) begin
                    dir_d = dir_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, packet latches and counters; reset discards any packet in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            dir_q        <= '0;
            // NOTE: the packet latches are cleared too, so mem_* outputs are defined from reset onward.
            addr_q       <= '0;
            f_q          <= '0;
            count_q      <= '0;
            node_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
            state_q      <= state_d;
            dir_q        <= dir_d;
            addr_q       <= addr_d;
            f_q          <= f_d;
            count_q      <= count_d;
            node_done_q  <= node_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.mem_we     = (state_q == WRITE) && !entry_invalid && !bus.mem_busy;
    assign bus.mem_dir    = (state_q == WRITE) ? dir_q : 4'd0;
    assign bus.mem_addr   = (state_q == WRITE) ? entry_addr[AW-2:0] : '0;
    assign bus.mem_wdata  = (state_q == WRITE) ? entry_data : '0;
    assign bus.node_done  = node_done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.node_count = count_q;
endmodule
